res_arbiter: RTL and testbench
==============================

# res_arbiter

Two-client arbiter that shares the single port of the 16384×8 result RAM (`res_rd`/`res_wr`/`res_addr`/`res_do`/`res_di`) between the image loader (client 0) and the distance-transform pass engine (client 1). It sits between the DT sub-blocks and the RAM interface at the top of `DT`. Arbitration is round-robin, with an optional lock for multi-access read-modify-write sequences. It also returns read data to the requesting client with fixed latency.

## Interface
- `ADDR_W`, 14, RAM address width
- `DATA_W`, 8, RAM data width

Ports:
- `clk`  in  1  single clock; RAM reads on negedge, writes on posedge
- `reset`  in  1  synchronous, active-low reset
- `req0`, `req1`  in  1  client access request
- `we0`, `we1`  in  1  1 = write, 0 = read; qualified by req
- `lock0`, `lock1`  in  1  keep ownership after this access
- `addr0`, `addr1`  in  ADDR_W  access address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `gnt0`, `gnt1`  out  1  combinational grant; access accepted on posedge where `req && gnt`
- `rvalid0`, `rvalid1`  out  1  read data valid for that client this cycle
- `rdata`  out  DATA_W  read data, common to both clients, equals `res_di`
- `res_rd`, `res_wr`  out  1  registered RAM strobes
- `res_addr`  out  ADDR_W  registered RAM address
- `res_do`  out  DATA_W  registered RAM write data
- `res_di`  in  DATA_W  RAM read data, updated at negedge

## Operation
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: a client holds the lock.
- Pointer `last` records the client of the most recent accepted access. Reset value is 1, so client 0 wins first.
- Grant in IDLE:
  - Only one req high: grant it.
  - Both high: grant `~last`.
  - Neither high: no grant.
- Grant in OWNn:
  - `reqn` = 1: grant n only; the other client is held off.
  - `reqn` = 0: ownership drops combinationally, state behaves as IDLE that cycle, and the other client may be granted.
- On acceptance by client n:
  - Register `res_addr` ← `addrn` and `res_do` ← `wdatan`.
  - Register `res_rd` ← `~wen` and `res_wr` ← `wen`.
  - `last` ← n.
  - Next state ← OWNn if `lockn`, else IDLE.
- No acceptance: `res_rd` = 0 and `res_wr` = 0 next cycle. `res_addr` and `res_do` hold.
- Read return: on acceptance of a read, `rvalidn` is registered high for exactly the next cycle. `rdata` = `res_di` during that cycle.
- `gnt0` and `gnt1` are never both high. `gnt` is 0 while `reset` = 0.
- Reset (`reset` = 0 at posedge), regardless of state or in-flight access:
  - IDLE, `last` = 1.
  - `res_rd`, `res_wr`, `rvalid0`, `rvalid1` = 0.
  - `res_addr` = 0, `res_do` = 0.
  - An access in flight is dropped; no `rvalid` is produced for it.

## Timing
- One access per cycle; back-to-back accesses from the same or different clients are allowed, giving full throughput.
- Access accepted at posedge E0:
  - RAM outputs are driven during E0–E1.
  - A write commits at E1.
  - A read is sampled by the RAM at the negedge between E0 and E1; `rvalid` and `rdata` are valid in E1–E2.
  - Read latency is 1 cycle.
- Write-then-read of the same address on consecutive accepts returns the new data, with no hazard stall. Reason: the write commits at E1 and the read samples at the negedge after E1.
- Grant depends combinationally on req, state and `last` only, not on addr/we/wdata.
- The client must hold req/we/addr/wdata/lock stable until acceptance.

## Test plan
- Reset then single client: `reset` low 2 cycles, then `req0`=1, `we0`=1, `addr0`=5, `wdata0`=8'h01 -> `gnt0`=1 the same cycle, `res_wr`=1 with `res_addr`=5 next cycle, RAM[5]=01.
- Contention: both clients request reads continuously, `lock` low -> grants alternate 0,1,0,1 starting with client 0; each `rvalid` pulses one cycle after its accept with the correct RAM byte.
- Lock: client 1 issues 3 accesses with `lock1`=1, 1, 0 while `req0` stays high -> `gnt0`=0 for all three; client 0 is granted on the fourth cycle.
- Write-read forward: accept write addr 100 data 8'h3C, then read addr 100 on the next accept -> `rvalid` next cycle with `rdata`=8'h3C.
- Owner drops req while in OWN1: `req1` falls, `req0` high -> `gnt0`=1 the same cycle, and the state returns to IDLE/OWN0 per `lock0`.
- Mid-access reset: read accepted, `reset` low at the next posedge -> `rvalid0`/`rvalid1` stay 0, `res_rd`=0, `res_addr`=0, and `gnt` stays 0 while reset is low.

Source files
------------

// File: rtl/res_arbiter.sv
// res_arbiter: round-robin arbiter with lock sharing the result RAM port
// between the image loader (client 0) and the DT pass engine (client 1).
module res_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              res_rd,
   output logic              res_wr,
   output logic [ADDR_W-1:0] res_addr,
   output logic [DATA_W-1:0] res_do,
   input  logic [DATA_W-1:0] res_di
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last;
   logic              r_pend0;
   logic              r_pend1;
   logic              r_rvalid0;
   logic              r_rvalid1;
   logic              r_rd;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_do;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_hold0;
   logic              w_hold1;

   // An owner that drops req releases the port in the same cycle.
   assign w_hold0 = (r_state == OWN0) && req0;
   assign w_hold1 = (r_state == OWN1) && req1;

   always_comb begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_state_nxt = IDLE;
      if (reset) begin
         if (w_hold0) begin
            w_gnt0 = 1'b1;
         end else if (w_hold1) begin
            w_gnt1 = 1'b1;
         end else if (req0 && req1) begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
         end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
         end
      end
      if (w_gnt0) begin
         w_state_nxt = lock0 ? OWN0 : IDLE;
      end else if (w_gnt1) begin
         w_state_nxt = lock1 ? OWN1 : IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_last    <= 1'b1;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_addr    <= '0;
         r_do      <= '0;
         r_pend0   <= 1'b0;
         r_pend1   <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rvalid0 <= r_pend0;
         r_rvalid1 <= r_pend1;
         r_pend0   <= w_gnt0 && !we0;
         r_pend1   <= w_gnt1 && !we1;
         if (w_gnt0) begin
            r_last <= 1'b0;
            r_addr <= addr0;
            r_do   <= wdata0;
            r_rd   <= ~we0;
            r_wr   <= we0;
         end else if (w_gnt1) begin
            r_last <= 1'b1;
            r_addr <= addr1;
            r_do   <= wdata1;
            r_rd   <= ~we1;
            r_wr   <= we1;
         end else begin
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
         end
      end
   end

   assign gnt0     = w_gnt0;
   assign gnt1     = w_gnt1;
   assign rvalid0  = r_rvalid0;
   assign rvalid1  = r_rvalid1;
   assign rdata    = res_di;
   assign res_rd   = r_rd;
   assign res_wr   = r_wr;
   assign res_addr = r_addr;
   assign res_do   = r_do;

endmodule

// File: tb/tb_res_arbiter.sv
// Directed bench for res_arbiter with a negedge-read / posedge-write
// model of the 16384x8 result RAM.
module tb_res_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic        lock0 = 0, lock1 = 0;
   logic [13:0] addr0 = '0, addr1 = '0;
   logic [7:0]  wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0]  rdata;
   logic        res_rd, res_wr;
   logic [13:0] res_addr;
   logic [7:0]  res_do;
   logic [7:0]  res_di = '0;
   logic [7:0]  mem [0:16383];

   int checks = 0;
   int errors = 0;

   res_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
      .res_rd(res_rd), .res_wr(res_wr),
      .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (res_rd) res_di <= mem[res_addr];
   always @(posedge clk) if (res_wr) mem[res_addr] <= res_do;

   function automatic logic [7:0] init_val(input int a);
      return 8'((a * 7 + 19) & 8'hFF);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b0;
      req0 = 1;
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b00) begin
         errors++;
         $display("FAIL rst_gnt got %b want 00", {gnt0, gnt1});
      end
      step();
      checks++;
      if ({res_rd, res_wr, rvalid0, rvalid1, res_addr, res_do} !== 26'd0) begin
         errors++;
         $display("FAIL rst_state got rd%b wr%b rv%b%b a%0d d%h want all 0",
                  res_rd, res_wr, rvalid0, rvalid1, res_addr, res_do);
      end
      idle_inputs();
      reset = 1'b1;
   endtask

   task automatic test_single_write();
      req0 = 1; we0 = 1; addr0 = 14'd5; wdata0 = 8'h01;
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++;
         $display("FAIL wr_gnt got %b want 10", {gnt0, gnt1});
      end
      step();
      idle_inputs();
      checks++;
      if ({res_wr, res_rd, res_addr, res_do} !== {1'b1, 1'b0, 14'd5, 8'h01}) begin
         errors++;
         $display("FAIL wr_strobe got wr%b rd%b a%0d d%h want wr1 rd0 a5 d01",
                  res_wr, res_rd, res_addr, res_do);
      end
      step();
      checks++;
      if ({res_wr, res_rd, res_addr, mem[5]} !== {1'b0, 1'b0, 14'd5, 8'h01}) begin
         errors++;
         $display("FAIL wr_commit got wr%b rd%b a%0d mem%h want wr0 rd0 a5 mem01",
                  res_wr, res_rd, res_addr, mem[5]);
      end
   endtask

   task automatic test_contention();
      int prev;
      do_reset();
      req0 = 1; req1 = 1; we0 = 0; we1 = 0;
      addr0 = 14'd10; addr1 = 14'd20;
      prev = -1;
      for (int i = 0; i < 5; i++) begin
         int c;
         c = i % 2;
         #1;
         checks++;
         if ({gnt0, gnt1} !== (c == 0 ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL cont_gnt%0d got %b want client %0d", i, {gnt0, gnt1}, c);
         end
         step();
         checks++;
         if (res_rd !== 1'b1 || res_addr !== (c == 0 ? 14'd10 : 14'd20)) begin
            errors++;
            $display("FAIL cont_acc%0d got rd%b a%0d", i, res_rd, res_addr);
         end
         if (prev >= 0) begin
            checks++;
            if ({rvalid0, rvalid1} !== (prev == 0 ? 2'b10 : 2'b01) ||
                rdata !== init_val(prev == 0 ? 10 : 20)) begin
               errors++;
               $display("FAIL cont_rv%0d got rv%b%b d%h want client %0d d%h",
                        i, rvalid0, rvalid1, rdata, prev,
                        init_val(prev == 0 ? 10 : 20));
            end
         end
         prev = c;
      end
      idle_inputs();
      step();
      checks++;
      if ({rvalid0, rvalid1} !== 2'b10 || rdata !== init_val(10)) begin
         errors++;
         $display("FAIL cont_rv_last got rv%b%b d%h want 10 d%h",
                  rvalid0, rvalid1, rdata, init_val(10));
      end
      step();
      checks++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
         errors++;
         $display("FAIL cont_rv_end got %b%b want 00", rvalid0, rvalid1);
      end
   endtask

   task automatic test_lock();
      req0 = 1; we0 = 0; addr0 = 14'd30;
      req1 = 1; we1 = 1; addr1 = 14'd40;
      for (int i = 0; i < 3; i++) begin
         lock1 = (i < 2);
         wdata1 = 8'(8'hB0 + i);
         #1;
         checks++;
         if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL lock_gnt%0d got %b want 01", i, {gnt0, gnt1});
         end
         step();
      end
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++;
         $display("FAIL lock_release got %b want 10", {gnt0, gnt1});
      end
      step();
      idle_inputs();
      step();
      checks++;
      if (mem[40] !== 8'hB2) begin
         errors++;
         $display("FAIL lock_wr got %h want b2", mem[40]);
      end
   endtask

   task automatic test_forward();
      req0 = 1; we0 = 1; addr0 = 14'd100; wdata0 = 8'h3C;
      step();
      we0 = 0;
      #1;
      checks++;
      if (gnt0 !== 1'b1) begin
         errors++;
         $display("FAIL fwd_gnt got %b want 1", gnt0);
      end
      step();
      idle_inputs();
      checks++;
      if ({res_rd, res_addr} !== {1'b1, 14'd100}) begin
         errors++;
         $display("FAIL fwd_rd got rd%b a%0d want rd1 a100", res_rd, res_addr);
      end
      step();
      checks++;
      if (rvalid0 !== 1'b1 || rdata !== 8'h3C) begin
         errors++;
         $display("FAIL fwd_data got rv%b d%h want rv1 d3c", rvalid0, rdata);
      end
   endtask

   task automatic test_drop_owner();
      req1 = 1; we1 = 0; lock1 = 1; addr1 = 14'd50;
      step();
      req1 = 0; lock1 = 0;
      req0 = 1; we0 = 0; lock0 = 1; addr0 = 14'd60;
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++;
         $display("FAIL drop_gnt got %b want 10", {gnt0, gnt1});
      end
      step();
      req1 = 1;
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++;
         $display("FAIL own0_hold got %b want 10", {gnt0, gnt1});
      end
      lock0 = 0;
      step();
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
         errors++;
         $display("FAIL own0_free got %b want 01", {gnt0, gnt1});
      end
      idle_inputs();
      step();
      step();
   endtask

   task automatic test_mid_reset();
      req0 = 1; we0 = 0; addr0 = 14'd10;
      step();
      reset = 1'b0;
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b00) begin
         errors++;
         $display("FAIL mid_gnt got %b want 00", {gnt0, gnt1});
      end
      step();
      checks++;
      if ({rvalid0, rvalid1, res_rd, res_addr} !== 17'd0) begin
         errors++;
         $display("FAIL mid_state got rv%b%b rd%b a%0d want 0",
                  rvalid0, rvalid1, res_rd, res_addr);
      end
      step();
      checks++;
      if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_hold got rv%b%b gnt%b%b want 0",
                  rvalid0, rvalid1, gnt0, gnt1);
      end
      idle_inputs();
      reset = 1'b1;
      step();
   endtask

   initial begin
      for (int a = 0; a < 16384; a++) mem[a] = init_val(a);
      test_reset();
      test_contention();
      test_lock();
      test_single_write();
      test_forward();
      test_drop_owner();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
